// File: rtl/lm_sm_sequencer_pkg.sv
// Shared constants and state type for the LM/SM load/store-multiple sequencer.
`default_nettype none

package lm_sm_sequencer_pkg;

  localparam int          ISA_ADDR_W = 16;
  localparam int          ISA_LIST_W = 8;
  localparam logic [3:0]  ISA_OP_LM  = 4'b0110;
  localparam logic [3:0]  ISA_OP_SM  = 4'b0111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/lm_sm_sequencer_lsb_priority_enc.sv
// Lowest-set-bit priority encoder with an "exactly one bit set" flag.
`default_nettype none

module lsb_priority_enc #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_hot
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign one_hot = (vec != '0) && ((vec & (vec - W'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
// Expands an LM/SM instruction into one memory transfer per set register-list bit.
`default_nettype none

module lm_sm_sequencer
  import lm_sm_sequencer_pkg::*;
#(
  parameter int         ADDR_W = ISA_ADDR_W,
  parameter int         LIST_W = ISA_LIST_W,
  parameter logic [3:0] OP_LM  = ISA_OP_LM,
  parameter logic [3:0] OP_SM  = ISA_OP_SM
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               ir_in,
  input  logic                      valid_in,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      hold_in,
  output logic                      xfer_valid,
  output logic [$clog2(LIST_W)-1:0] xfer_reg,
  output logic [ADDR_W-1:0]         xfer_addr,
  output logic                      mem_write,
  output logic                      rf_write,
  output logic                      seq_done,
  output logic                      stall_out,
  output logic                      busy
);

  localparam int IDX_W = $clog2(LIST_W);

  seq_state_t          state;
  logic [LIST_W-1:0]   list_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                is_sm_q;

  logic [3:0]          opcode;
  logic [IDX_W-1:0]    idx;
  logic                last;
  logic                accept;
  logic                run;
  logic                issue;
  logic                unused_ir;

  // RA field is consumed upstream as base_addr; only opcode and list matter here.
  assign unused_ir = ^ir_in[11:LIST_W];
  assign opcode    = ir_in[15:12];

  lsb_priority_enc #(
    .W     (LIST_W),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec     (list_q),
    .idx     (idx),
    .one_hot (last)
  );

  assign accept = !reset && (state == ST_IDLE) && valid_in &&
                  ((opcode == OP_LM) || (opcode == OP_SM)) &&
                  (ir_in[LIST_W-1:0] != '0);
  assign run    = !reset && (state == ST_RUN);
  assign issue  = run && !hold_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      is_sm_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            list_q  <= ir_in[LIST_W-1:0];
            addr_q  <= base_addr;
            is_sm_q <= (opcode == OP_SM);
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!hold_in) begin
            // x & (x-1) drops exactly the lowest set bit, i.e. the one just issued.
            list_q <= list_q & (list_q - LIST_W'(1));
            addr_q <= addr_q + ADDR_W'(1);
            if (last) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign xfer_valid = issue;
  assign xfer_reg   = issue ? idx : '0;
  assign xfer_addr  = issue ? addr_q : '0;
  assign mem_write  = issue && is_sm_q;
  assign rf_write   = issue && !is_sm_q;
  assign seq_done   = issue && last;
  assign stall_out  = accept || (run && !(last && !hold_in));
  assign busy       = run;

endmodule

`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
// Self-checking bench for lm_sm_sequencer against a transfer-list reference model.
`default_nettype none

module tb_lm_sm_sequencer;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir_in;
  logic        valid_in;
  logic [15:0] base_addr;
  logic        hold_in;
  logic        xfer_valid;
  logic [2:0]  xfer_reg;
  logic [15:0] xfer_addr;
  logic        mem_write;
  logic        rf_write;
  logic        seq_done;
  logic        stall_out;
  logic        busy;
  logic [24:0] outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .ir_in      (ir_in),
    .valid_in   (valid_in),
    .base_addr  (base_addr),
    .hold_in    (hold_in),
    .xfer_valid (xfer_valid),
    .xfer_reg   (xfer_reg),
    .xfer_addr  (xfer_addr),
    .mem_write  (mem_write),
    .rf_write   (rf_write),
    .seq_done   (seq_done),
    .stall_out  (stall_out),
    .busy       (busy)
  );

  // {xfer_valid, xfer_reg, xfer_addr, mem_write, rf_write, seq_done, stall_out, busy}
  assign outs = {xfer_valid, xfer_reg, xfer_addr, mem_write, rf_write, seq_done, stall_out, busy};

  // Accepts one instruction, then walks the expected transfer list (ascending set bits,
  // consecutive addresses from base) while optionally freezing with hold_in.
  task automatic run_seq(input bit is_sm, input logic [7:0] list, input logic [15:0] base,
                         input int hold_pct, input logic [31:0] hold_mask, input string tag,
                         output int stalls, output int strobes);
    int          regs[$];
    int          k;
    int          j;
    int          n;
    logic [24:0] exp;
    regs = {};
    for (int b = 0; b < 8; b++) if (list[b]) regs.push_back(b);
    n = regs.size();
    stalls = 0;
    strobes = 0;
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b1;
    ir_in = {is_sm ? OP_SM : OP_LM, 4'($urandom), list};
    base_addr = base;
    hold_in = 1'b0;
    #1;
    exp = 25'b0_000_0000000000000000_000_1_0;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s accept: got %b expected %b", tag, outs, exp);
    end
    stalls += int'(stall_out);
    k = 0;
    j = 0;
    while (k < n) begin
      @(negedge clk);
      valid_in = 1'($urandom_range(0, 1));
      ir_in = 16'($urandom);
      base_addr = 16'($urandom);
      hold_in = ((j < 32) && hold_mask[j]) || (int'($urandom_range(0, 99)) < hold_pct);
      #1;
      if (hold_in)
        exp = 25'b0_000_0000000000000000_000_1_1;
      else
        exp = {1'b1, 3'(regs[k]), base + 16'(k), is_sm, !is_sm, (k == n - 1), (k != n - 1), 1'b1};
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL %s xfer k=%0d hold=%0b: got %b expected %b", tag, k, hold_in, outs, exp);
      end
      stalls += int'(stall_out);
      strobes += int'(mem_write | rf_write);
      if (!hold_in) k++;
      j++;
      if (j > 400) begin
        errors++;
        $display("FAIL %s cycle budget exceeded: got k=%0d expected %0d", tag, k, n);
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    exp = '0;
    reset = 1'b1;
    valid_in = 1'b1;
    ir_in = {OP_LM, 4'h0, 8'hFF};
    base_addr = 16'h1234;
    hold_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_cycle: got %b expected %b", outs, exp);
    end
    @(negedge clk);
    reset = 1'b0;
    valid_in = 1'b0;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", outs, exp);
    end
  endtask

  task automatic test_lm_basic();
    int st, sb;
    run_seq(1'b0, 8'b1010_0101, 16'h0040, 0, 32'h0, "lm_basic", st, sb);
    checks++;
    if (st !== 4) begin
      errors++;
      $display("FAIL lm_basic stall_cycles: got %0d expected 4", st);
    end
  endtask

  task automatic test_sm_single();
    int st, sb;
    run_seq(1'b1, 8'h80, 16'h0100, 0, 32'h0, "sm_single", st, sb);
    checks++;
    if (st !== 1 || sb !== 1) begin
      errors++;
      $display("FAIL sm_single stalls/strobes: got %0d/%0d expected 1/1", st, sb);
    end
  endtask

  task automatic test_wrap();
    int st, sb;
    run_seq(1'b0, 8'h07, 16'hFFFE, 0, 32'h0, "wrap", st, sb);
  endtask

  task automatic test_hold();
    int st, sb;
    run_seq(1'b1, 8'h0F, 16'h0200, 0, 32'h0000_0006, "hold", st, sb);
    checks++;
    if (sb !== 4) begin
      errors++;
      $display("FAIL hold strobes: got %0d expected 4", sb);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] exp;
    int st, sb;
    @(negedge clk);
    valid_in = 1'b1;
    ir_in = {OP_LM, 4'h2, 8'hFF};
    base_addr = 16'h0300;
    hold_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    exp = {1'b1, 3'd0, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_mid first: got %b expected %b", outs, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp = '0;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_mid reset_cycle: got %b expected %b", outs, exp);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL reset_mid after: got %b expected %b", outs, exp);
    end
    run_seq(1'b1, 8'h01, 16'h0555, 0, 32'h0, "reset_mid_sm", st, sb);
  endtask

  task automatic test_nop();
    logic [24:0] exp;
    exp = '0;
    @(negedge clk);
    valid_in = 1'b1;
    ir_in = {OP_LM, 4'h3, 8'h00};
    hold_in = 1'b0;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL nop_lm_empty: got %b expected %b", outs, exp);
    end
    @(negedge clk);
    ir_in = {4'b0000, 12'h5A5};
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL nop_add: got %b expected %b", outs, exp);
    end
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    checks++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL nop_stays_idle: got %b expected %b", outs, exp);
    end
  endtask

  task automatic test_random();
    int          st, sb;
    logic [7:0]  list;
    logic [15:0] insn;
    logic [24:0] exp;
    for (int s = 0; s < 25; s++) begin
      list = 8'($urandom_range(1, 255));
      run_seq(1'($urandom_range(0, 1)), list, 16'($urandom), 30, 32'h0, "random", st, sb);
      checks++;
      if (sb !== $countones(list)) begin
        errors++;
        $display("FAIL random strobes: got %0d expected %0d", sb, $countones(list));
      end
      // Idle cycle with a non-LM/SM instruction must leave everything quiet.
      @(negedge clk);
      insn = 16'($urandom);
      if (insn[15:13] == 3'b011) insn[15] = 1'b1;
      valid_in = 1'b1;
      ir_in = insn;
      hold_in = 1'($urandom_range(0, 1));
      #1;
      exp = '0;
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL random idle_other: got %b expected %b", outs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st, sb;
    run_seq(1'b0, 8'h03, 16'h7FFF, 0, 32'h0, "b2b_a", st, sb);
    run_seq(1'b1, 8'hC0, 16'h0010, 0, 32'h0, "b2b_b", st, sb);
    checks++;
    if (sb !== 2) begin
      errors++;
      $display("FAIL b2b strobes: got %0d expected 2", sb);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    ir_in = '0;
    base_addr = '0;
    hold_in = 1'b0;
    test_reset();
    test_lm_basic();
    test_sm_single();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_nop();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
